// File: rtl/display_pkg.sv
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants for the up/down display counter: digit
//                width, the blank pattern and the active-low 7-segment
//                glyphs for 0-F. Segment bit order is g..a, so bit 6 is g
//                and bit 0 is a.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;  // lower-case "b"
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;  // lower-case "d"
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational hex digit to active-low 7-segment decode.
//  Ports       : value_i [3:0]  digit value 0-F
//                seg_o   [6:0]  active-low segments, order g..a
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] value_i,
    output logic [6:0]         seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/updown_display_counter.sv
// ============================================================================
//  Module      : updown_display_counter
//  Description : Multi-digit up/down counter with prescaler, hex or BCD radix,
//                synchronous clear/load, registered wrap pulse and per-digit
//                active-low 7-segment outputs.
//  Parameters  : DIGITS   number of 4-bit digits
//                BCD      0 = binary/hex wrap, 1 = each digit 0-9
//                TICK_DIV enabled cycles per count step (>= 1)
//  Ports       : clock, resetn (async, active-low), clear_n (sync, active-low),
//                enable, up, load, load_value, count, tc, hex
//  Macro       : LEADING_ZERO_BLANK_EN - blanks digits above the most
//                significant nonzero digit (digit 0 always lit).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module updown_display_counter
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int TICK_DIV = 1
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        clear_n,
    input  logic                        enable,
    input  logic                        up,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_value,
    output logic [DIGIT_W*DIGITS-1:0]   count,
    output logic                        tc,
    output logic [7*DIGITS-1:0]         hex
);

    localparam int W  = DIGIT_W * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          tc_q, tc_d;

    logic [W-1:0]  w_step_val;
    logic          w_step_wrap;
    logic [W-1:0]  w_load_sat;

    // In BCD mode a loaded digit above 9 saturates to 9 so the count never
    // leaves the decimal range.
    always_comb begin
        w_load_sat = load_value;
        if (BCD != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (load_value[DIGIT_W*i +: DIGIT_W] > 4'd9) begin
                    w_load_sat[DIGIT_W*i +: DIGIT_W] = 4'd9;
                end
            end
        end
    end

    if (BCD != 0) begin : g_bcd_step
        logic               w_carry;
        logic [DIGIT_W-1:0] w_dig;

        // Ripple carry/borrow from digit 0 upwards; a carry surviving past
        // the top digit is the wrap.
        always_comb begin
            w_step_val = count_q;
            w_carry    = 1'b1;
            w_dig      = '0;
            for (int i = 0; i < DIGITS; i++) begin
                w_dig = count_q[DIGIT_W*i +: DIGIT_W];
                if (w_carry) begin
                    if (up) begin
                        if (w_dig >= 4'd9) begin
                            w_step_val[DIGIT_W*i +: DIGIT_W] = 4'd0;
                        end else begin
                            w_step_val[DIGIT_W*i +: DIGIT_W] = w_dig + 4'd1;
                            w_carry = 1'b0;
                        end
                    end else begin
                        if (w_dig == 4'd0) begin
                            w_step_val[DIGIT_W*i +: DIGIT_W] = 4'd9;
                        end else begin
                            w_step_val[DIGIT_W*i +: DIGIT_W] = w_dig - 4'd1;
                            w_carry = 1'b0;
                        end
                    end
                end
            end
            w_step_wrap = w_carry;
        end
    end else begin : g_hex_step
        always_comb begin
            w_step_val  = up ? (count_q + W'(1)) : (count_q - W'(1));
            w_step_wrap = up ? (&count_q) : ~(|count_q);
        end
    end

    // Priority: clear > load > prescaled step. tc only follows a step.
    always_comb begin
        count_d = count_q;
        ps_d    = ps_q;
        tc_d    = 1'b0;
        if (!clear_n) begin
            count_d = '0;
            ps_d    = '0;
        end else if (load) begin
            count_d = w_load_sat;
            ps_d    = '0;
        end else if (enable) begin
            if (ps_q == PS_LAST) begin
                ps_d    = '0;
                count_d = w_step_val;
                tc_d    = w_step_wrap;
            end else begin
                ps_d = ps_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            ps_q    <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ps_q    <= ps_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [6:0] w_seg;
        logic       w_lit;

        seg7_decoder u_dec (
            .value_i (count_q[DIGIT_W*i +: DIGIT_W]),
            .seg_o   (w_seg)
        );

`ifdef LEADING_ZERO_BLANK_EN
        // A digit is lit if it or any more significant digit is nonzero.
        if (i == 0) begin : g_lsd
            assign w_lit = 1'b1;
        end else begin : g_upper
            assign w_lit = |count_q[W-1:DIGIT_W*i];
        end
`else
        assign w_lit = 1'b1;
`endif

        assign hex[7*i +: 7] = w_lit ? w_seg : SEG_BLANK;
    end

endmodule

`default_nettype wire

// File: tb/tb_updown_display_counter.sv
// ============================================================================
//  Module      : tb_updown_display_counter
//  Description : Self-checking bench. Three counter instances: hex
//                (TICK_DIV=1), BCD (TICK_DIV=1) and hex with TICK_DIV=5.
//                Vectors are applied one clock per entry; expectations are
//                queued when stimulus is driven and compared after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updown_display_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        clr_n [3];
    logic        en    [3];
    logic        dir   [3];
    logic        ld    [3];
    logic [15:0] lv    [3];

    logic [15:0] h_cnt, b_cnt, p_cnt;
    logic        h_tc,  b_tc,  p_tc;
    logic [27:0] h_hex, b_hex, p_hex;

    updown_display_counter #(.DIGITS(4), .BCD(0), .TICK_DIV(1)) u_hex (
        .clock(clk), .resetn(resetn), .clear_n(clr_n[0]), .enable(en[0]),
        .up(dir[0]), .load(ld[0]), .load_value(lv[0]),
        .count(h_cnt), .tc(h_tc), .hex(h_hex)
    );

    updown_display_counter #(.DIGITS(4), .BCD(1), .TICK_DIV(1)) u_bcd (
        .clock(clk), .resetn(resetn), .clear_n(clr_n[1]), .enable(en[1]),
        .up(dir[1]), .load(ld[1]), .load_value(lv[1]),
        .count(b_cnt), .tc(b_tc), .hex(b_hex)
    );

    updown_display_counter #(.DIGITS(4), .BCD(0), .TICK_DIV(5)) u_pre (
        .clock(clk), .resetn(resetn), .clear_n(clr_n[2]), .enable(en[2]),
        .up(dir[2]), .load(ld[2]), .load_value(lv[2]),
        .count(p_cnt), .tc(p_tc), .hex(p_hex)
    );

    typedef struct {
        int          inst;
        logic        clr_n;
        logic        en;
        logic        up;
        logic        ld;
        logic [15:0] lv;
        logic [15:0] cnt;
        logic        tc;
    } vec_t;

    typedef struct {
        int          id;
        int          inst;
        logic [15:0] cnt;
        logic        tc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int inst, input logic c, input logic e,
                                input logic u, input logic l, input logic [15:0] v,
                                input logic [15:0] cnt, input logic t);
        vec_t r;
        r.inst = inst; r.clr_n = c; r.en = e; r.up = u; r.ld = l; r.lv = v;
        r.cnt = cnt; r.tc = t;
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] c);
        logic [27:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg_of(c[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (i > 0 && (c >> (4*i)) == 16'h0) r[7*i +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    task automatic compare(input int id, input int inst, input logic [15:0] ac,
                           input logic at, input logic [27:0] ah,
                           input logic [15:0] ec, input logic et);
        logic [27:0] eh;
        eh = exp_hex(ec);
        checks++;
        if (ac !== ec || at !== et || ah !== eh) begin
            errors++;
            $display("FAIL vec%0d inst%0d: got count=%h tc=%b hex=%h, expected count=%h tc=%b hex=%h",
                     id, inst, ac, at, ah, ec, et, eh);
        end
    endtask

    task automatic score();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0:       compare(e.id, 0, h_cnt, h_tc, h_hex, e.cnt, e.tc);
                1:       compare(e.id, 1, b_cnt, b_tc, b_hex, e.cnt, e.tc);
                default: compare(e.id, 2, p_cnt, p_tc, p_hex, e.cnt, e.tc);
            endcase
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            clr_n[i] = 1'b1; en[i] = 1'b0; dir[i] = 1'b1; ld[i] = 1'b0; lv[i] = 16'h0;
        end
    endtask

    task automatic push(input int id, input int inst, input logic [15:0] c, input logic t);
        exp_t e;
        e.id = id; e.inst = inst; e.cnt = c; e.tc = t;
        sb.push_back(e);
    endtask

    task automatic apply(input int id, input vec_t v);
        @(negedge clk);
        idle_all();
        clr_n[v.inst] = v.clr_n;
        en[v.inst]    = v.en;
        dir[v.inst]   = v.up;
        ld[v.inst]    = v.ld;
        lv[v.inst]    = v.lv;
        push(id, v.inst, v.cnt, v.tc);
        @(posedge clk);
        #1;
        score();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        // Hex instance: wrap up/down, hold, clear-vs-load, load-vs-step
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'hFFFE, 16'hFFFE, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'h0001, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 16'h0000, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'h0042, 16'h0042, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 16'h1234, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 16'hABCD, 16'hABCD, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 16'h0000, 16'h0001, 0));
        // BCD instance: borrow, wrap both ways, saturating load
        vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0100, 16'h0100, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0099, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h0098, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h9999, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1));
        vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 16'h0001, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 16'h00AF, 16'h0099, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 16'h0000, 16'h0100, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 16'hFA9B, 16'h9999, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 16'h0000, 16'h9998, 0));
        // Prescaler instance (TICK_DIV=5): 12 enabled, 3 held, 3 enabled
        for (int k = 1; k <= 12; k++)
            vecs.push_back(mk(2, 1, 1, 1, 0, 16'h0, (k >= 10) ? 16'd2 : (k >= 5) ? 16'd1 : 16'd0, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(2, 1, 0, 1, 0, 16'h0, 16'd2, 0));
        for (int k = 1; k <= 3; k++)
            vecs.push_back(mk(2, 1, 1, 1, 0, 16'h0, (k == 3) ? 16'd3 : 16'd2, 0));

        // ---------------- reset state ----------------
        idle_all();
        resetn = 1'b0;
        #2;
        push(-1, 0, 16'h0, 0);
        push(-1, 1, 16'h0, 0);
        push(-1, 2, 16'h0, 0);
        score();
        #1;
        resetn = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // ---------------- async reset mid-count ----------------
        apply(100, mk(0, 1, 0, 1, 1, 16'h1234, 16'h1234, 0));
        @(negedge clk);
        idle_all();
        en[0] = 1'b1;
        dir[0] = 1'b1;
        resetn = 1'b0;
        #2;
        push(101, 0, 16'h0, 0);
        push(102, 1, 16'h0, 0);
        push(103, 2, 16'h0, 0);
        score();
        @(negedge clk);
        resetn = 1'b1;
        push(104, 0, 16'h0001, 0);
        @(posedge clk);
        #1;
        score();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/updown_display_counter.md
# updown_display_counter

Parametrised multi-digit up/down counter with a built-in count prescaler, hex or BCD radix, synchronous load and clear, wrap pulse and per-digit active-low 7-segment outputs. It sits between the board switches/keys and the HEX displays. It replaces the fixed 16-bit hex up-counter with one block that covers any digit count, a decimal mode and counting from the 50 MHz board clock.

## Interface
- `DIGITS`, 4: number of 4-bit digits; count width is 4*DIGITS.
- `BCD`, 0: 0 = hex, binary wrap; 1 = each digit counts 0–9.
- `TICK_DIV`, 1: enabled clock cycles per count step; must be ≥ 1.

- `clock`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `clear_n`  in  1  synchronous clear, active-low.
- `enable`  in  1  count enable.
- `up`  in  1  direction: 1 = up, 0 = down.
- `load`  in  1  synchronous load strobe.
- `load_value`  in  4*DIGITS  value to load; digit i is bits [4i+3:4i].
- `count`  out  4*DIGITS  current count, registered.
- `tc`  out  1  one-cycle wrap pulse, registered.
- `hex`  out  7*DIGITS  active-low segments; digit i is bits [7i+6:7i], segment order g..a.

## Operation
- Priority per edge: `resetn` low > `clear_n` low > `load` > step.
- Reset values: `count`=0, prescaler=0, `tc`=0, each `hex` digit=7'b1000000 ("0"), subject to the Configuration section.
- The prescaler runs 0..TICK_DIV-1 and advances only while `enable`=1.
- A step happens when `enable`=1 and prescaler = TICK_DIV-1. On that cycle the prescaler returns to 0.
- With `enable`=0, the prescaler and `count` hold.
- Clear sets `count`=0 and prescaler=0. Load sets `count` to `load_value` and prescaler=0.
- Clear and load do not step and do not assert `tc`.
- BCD load: any digit >9 is stored as 9.
- Hex step: `count` ± 1 modulo 2^(4*DIGITS).
- BCD step: ripple carry or borrow per digit. Counting up, 9 goes to 0 with a carry. Counting down, 0 goes to 9 with a borrow. The full range is 0..10^DIGITS-1.
- Wrap conditions:
  - up from max → 0;
  - down from 0 → max (all F in hex mode, all 9 in BCD mode).
- `tc` is 1 only in the cycle that follows a wrapping step.
- Each `hex` digit is a combinational decode of its `count` digit:
  - 0–9 → "0"–"9";
  - A–F → "A", "b", "C", "d", "E", "F".

## Timing
- `count` updates on the clock edge where a step, load or clear is taken. `hex` follows `count` with no added latency.
- `tc` is registered and asserts together with the wrapped `count` value, for exactly one cycle.
  - Consecutive wraps, e.g. DIGITS=1 with TICK_DIV=1, can produce back-to-back pulses.
- A step occurs every TICK_DIV enabled cycles. From prescaler=0, the first step lands on the TICK_DIV-th enabled edge.
- Changing `up` mid-count takes effect on the next step; the prescaler is not affected.
- Asserting `resetn` mid-count zeroes all state immediately, without waiting for a clock edge. State is released on the first edge after deassertion.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - every digit above the most-significant nonzero digit drives 7'b1111111;
  - digit 0 is always displayed, so count 0 shows a single "0".
- Not defined: all DIGITS digits are always displayed.
- The macro does not change `count` or `tc`.

## Structure
- Package `display_pkg` holds:
  - `SEG_BLANK` = 7'b1111111;
  - the 16 segment constants for 0–F;
  - `DIGIT_W` = 4.
- Sub-module `seg7_decoder`: 4-bit value in, 7-bit active-low segments out. It is instantiated DIGITS times in a generate loop.
- Prescaler width is max(1, $clog2(TICK_DIV)).

## Test plan
- Reset (DIGITS=4, BCD=0): pull `resetn` low mid-count at 16'h1234 → `count`=0, `tc`=0, all four `hex`=1000000 with no clock edge.
- Hex wrap (TICK_DIV=1): load 16'hFFFE, `enable`=1, `up`=1 → FFFF, then 0000 with `tc` high for that one cycle only.
- BCD down (BCD=1): load 16'h0100, `up`=0 → 0099, 0098. Then load 0000 and step → 9999 with a `tc` pulse. Loading 16'h00AF stores 0099.
- Prescaler (TICK_DIV=5): from 0 with `enable` high for 12 cycles → `count`=2. Drop `enable` for 3 cycles → holds. Re-enable → the next step comes after 3 more cycles.
- Priority:
  - `clear_n`=0 and `load`=1 on the same edge → 0.
  - `load`=1 with a due step → exactly `load_value`, no `tc`.
- With `LEADING_ZERO_BLANK_EN`:
  - `count`=16'h0042 → hex3 and hex2 blank, hex1 "4", hex0 "2";
  - `count`=0 → only hex0 lit, showing "0".
